stack_controller: RTL and testbench
===================================

// Module: stack_controller
// PURPOSE
//  Multicycle control FSM for the 8-bit stack-machine datapath. Consumes the latched
//  instruction and ALU Zero flag; drives every load, select, memory, stack and ALU-op
//  control of the datapath. One instruction executes at a time; each returns to FETCH.
// PARAMETERS
//  INST_W  9  instruction input width; opcode = inst[7:5], operand addr = inst[4:0], inst[8] ignored
// PORTS
//  clk            input   1  single system clock, all state on rising edge
//  rst            input   1  synchronous, active-high reset
//  inst           input   9  IR contents from datapath
//  Zero           input   1  ALU zero flag (combinational, same cycle)
//  ld_PC,ld_IR,ld_A output 1 register loads
//  MemRead,MemWrite output 1 memory strobes (write data = A)
//  push,pop,top   output  1  stack controls; pop/top present top on d_out same cycle, pop removes it
//  PCsrc          output  1  0=ALU result, 1=inst[4:0]
//  s1             output  1  mem addr: 0=PC, 1=inst[4:0]
//  s2             output  1  ALU B: 0=B reg, 1=const 1
//  s3             output  2  ALU A: 00=A reg, 01=PC, 10=0
//  s4             output  1  stack data in: 0=MDR, 1=ALU reg
//  ALU_operation  output  3  000 add, 001 sub, 010 and, 011 not A, 100 pass A
//  instr_done     output  1  1-cycle pulse in last state of every instruction
// BEHAVIOUR
//  - Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH a, 101 POP a, 110 JMP a, 111 JZ a.
//  - Moore FSM, outputs decoded from state (+Zero in JZ_EX). Unlisted outputs = 0 in every state.
//  - rst: state <= FETCH; while rst=1 all outputs forced 0 (no PC/mem/stack update).
//    Reset mid-instruction abandons it; first FETCH is the cycle after rst falls.
//  - FETCH: MemRead,s1=0,ld_IR, s3=01,s2=1,add, PCsrc=0,ld_PC (PC<=PC+1) -> DECODE.
//  - DECODE: JMP: PCsrc=1,ld_PC,instr_done -> FETCH. PUSH->PUSH_MEM; POP->POP_RD;
//    ADD/SUB/AND/NOT->OP_A; JZ->JZ_TOP.
//  - PUSH_MEM: s1=1,MemRead (MDR captures) -> PUSH_WR: s4=0,push,instr_done -> FETCH.
//  - POP_RD: pop,ld_A -> POP_WR: s1=1,MemWrite,instr_done -> FETCH.
//  - OP_A: pop,ld_A; NOT -> OP_EX, else -> OP_B. OP_B: pop (B captures) -> OP_EX.
//  - OP_EX: s3=00,s2=0, ALU_operation per opcode (ALU reg captures A op B) -> OP_WB.
//  - OP_WB: s4=1,push,instr_done -> FETCH. A = first popped (old top), B = second.
//  - JZ_TOP: top,ld_A (no removal) -> JZ_EX: s3=00,pass A; if Zero: PCsrc=1,ld_PC;
//    instr_done -> FETCH. Nonzero: PC unchanged (already PC+1).
//  - Latency (cycles incl. FETCH): JMP 2, PUSH 4, POP 4, JZ 4, NOT 5, ADD/SUB/AND 6.
//  - push and pop never asserted together; MemRead and MemWrite never together.
//  - PC wraps 31->0 via 5-bit truncation of ALU result; no stack full/empty checking here.
//  - No illegal states: unused state encodings -> FETCH with all outputs 0.
// TESTING
//  - rst held 3 cycles mid-ADD -> all outputs 0 during rst; FETCH (ld_IR=1,MemRead=1) cycle after release.
//  - inst=100_00011 (PUSH 3) -> FETCH,DECODE,PUSH_MEM(s1=1,MemRead),PUSH_WR(push,s4=0,instr_done); 4 cycles.
//  - inst=000_xxxxx (ADD) -> pop in OP_A and OP_B, ALU_operation=000,s2=0,s3=00 in OP_EX, push,s4=1 in OP_WB; 6 cycles.
//  - inst=011_xxxxx (NOT) -> single pop, ALU_operation=011, 5 cycles, exactly one push.
//  - inst=111_01010 (JZ 10), Zero=1 -> JZ_EX asserts PCsrc=1,ld_PC=1; with Zero=0 ld_PC=0; top=1,pop=0 in JZ_TOP.
//  - inst=110_11111 (JMP 31) -> DECODE asserts PCsrc=1,ld_PC=1,instr_done; next cycle FETCH.

Source files
------------

// File: rtl/stack_controller_if.sv
// Control bundle between the stack-machine controller and its datapath.
// master = controller side, slave = datapath side.
interface stack_controller_if #(parameter int INST_W = 9);
  logic [INST_W-1:0] inst;
  logic              Zero;
  logic              ld_PC, ld_IR, ld_A;
  logic              MemRead, MemWrite;
  logic              push, pop, top;
  logic              PCsrc, s1, s2, s4;
  logic [1:0]        s3;
  logic [2:0]        ALU_operation;
  logic              instr_done;

  modport master (
    input  inst, Zero,
    output ld_PC, ld_IR, ld_A, MemRead, MemWrite, push, pop, top,
           PCsrc, s1, s2, s3, s4, ALU_operation, instr_done
  );

  modport slave (
    output inst, Zero,
    input  ld_PC, ld_IR, ld_A, MemRead, MemWrite, push, pop, top,
           PCsrc, s1, s2, s3, s4, ALU_operation, instr_done
  );
endinterface

// File: rtl/stack_controller.sv
// Multicycle control FSM for the 8-bit stack-machine datapath.
// One instruction at a time; every instruction starts in FETCH and returns there.
module stack_controller #(
  parameter int INST_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  stack_controller_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    PUSH_MEM = 4'd2,
    PUSH_WR  = 4'd3,
    POP_RD   = 4'd4,
    POP_WR   = 4'd5,
    OP_A     = 4'd6,
    OP_B     = 4'd7,
    OP_EX    = 4'd8,
    OP_WB    = 4'd9,
    JZ_TOP   = 4'd10,
    JZ_EX    = 4'd11
  } state_t;

  localparam logic [2:0] OPC_NOT  = 3'b011;
  localparam logic [2:0] OPC_PUSH = 3'b100;
  localparam logic [2:0] OPC_POP  = 3'b101;
  localparam logic [2:0] OPC_JMP  = 3'b110;
  localparam logic [2:0] OPC_JZ   = 3'b111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_PASS = 3'b100;

  typedef struct packed {
    logic       ld_pc, ld_ir, ld_a;
    logic       mem_rd, mem_wr;
    logic       push, pop, top;
    logic       pc_src, s1, s2;
    logic [1:0] s3;
    logic       s4;
    logic [2:0] alu_op;
    logic       done;
  } ctrl_t;

  state_t     state, state_nxt;
  ctrl_t      ctrl;
  logic [2:0] opcode;

  // inst[8] and the operand field only matter to the datapath
  logic unused_inst;
  assign unused_inst = ^bus.inst;
  assign opcode      = bus.inst[7:5];

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:    state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OPC_JMP:  state_nxt = FETCH;
          OPC_PUSH: state_nxt = PUSH_MEM;
          OPC_POP:  state_nxt = POP_RD;
          OPC_JZ:   state_nxt = JZ_TOP;
          default:  state_nxt = OP_A;
        endcase
      end
      PUSH_MEM: state_nxt = PUSH_WR;
      POP_RD:   state_nxt = POP_WR;
      OP_A:     state_nxt = (opcode == OPC_NOT) ? OP_EX : OP_B;
      OP_B:     state_nxt = OP_EX;
      OP_EX:    state_nxt = OP_WB;
      JZ_TOP:   state_nxt = JZ_EX;
      default:  state_nxt = FETCH;
    endcase
  end

  // Outputs are forced quiet during reset so nothing in the datapath moves.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        FETCH: begin
          ctrl.mem_rd = 1'b1;
          ctrl.ld_ir  = 1'b1;
          ctrl.s3     = 2'b01;
          ctrl.s2     = 1'b1;
          ctrl.alu_op = ALU_ADD;
          ctrl.ld_pc  = 1'b1;
        end
        DECODE: begin
          if (opcode == OPC_JMP) begin
            ctrl.pc_src = 1'b1;
            ctrl.ld_pc  = 1'b1;
            ctrl.done   = 1'b1;
          end
        end
        PUSH_MEM: begin
          ctrl.s1     = 1'b1;
          ctrl.mem_rd = 1'b1;
        end
        PUSH_WR: begin
          ctrl.push = 1'b1;
          ctrl.done = 1'b1;
        end
        POP_RD: begin
          ctrl.pop  = 1'b1;
          ctrl.ld_a = 1'b1;
        end
        POP_WR: begin
          ctrl.s1     = 1'b1;
          ctrl.mem_wr = 1'b1;
          ctrl.done   = 1'b1;
        end
        OP_A: begin
          ctrl.pop  = 1'b1;
          ctrl.ld_a = 1'b1;
        end
        OP_B:  ctrl.pop = 1'b1;
        // only ADD/SUB/AND/NOT reach here, and their opcodes equal the ALU codes
        OP_EX: ctrl.alu_op = opcode;
        OP_WB: begin
          ctrl.s4   = 1'b1;
          ctrl.push = 1'b1;
          ctrl.done = 1'b1;
        end
        JZ_TOP: begin
          ctrl.top  = 1'b1;
          ctrl.ld_a = 1'b1;
        end
        JZ_EX: begin
          ctrl.alu_op = ALU_PASS;
          ctrl.done   = 1'b1;
          if (bus.Zero) begin
            ctrl.pc_src = 1'b1;
            ctrl.ld_pc  = 1'b1;
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign bus.ld_PC         = ctrl.ld_pc;
  assign bus.ld_IR         = ctrl.ld_ir;
  assign bus.ld_A          = ctrl.ld_a;
  assign bus.MemRead       = ctrl.mem_rd;
  assign bus.MemWrite      = ctrl.mem_wr;
  assign bus.push          = ctrl.push;
  assign bus.pop           = ctrl.pop;
  assign bus.top           = ctrl.top;
  assign bus.PCsrc         = ctrl.pc_src;
  assign bus.s1            = ctrl.s1;
  assign bus.s2            = ctrl.s2;
  assign bus.s3            = ctrl.s3;
  assign bus.s4            = ctrl.s4;
  assign bus.ALU_operation = ctrl.alu_op;
  assign bus.instr_done    = ctrl.done;

endmodule

// File: tb/tb_stack_controller.sv
// Cycle-by-cycle scoreboard bench for stack_controller: the stimulus process queues
// the expected control word for each cycle, the monitor pops and compares on negedge.
module tb_stack_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_controller_if #(.INST_W(9)) bus ();

  stack_controller #(.INST_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [17:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {ld_PC,ld_IR,ld_A,MemRead,MemWrite,push,pop,top,PCsrc,s1,s2,s3[1:0],s4,alu[2:0],instr_done}
  function automatic logic [17:0] cv(bit ldpc, bit ldir, bit lda, bit mr, bit mw,
                                     bit pu, bit po, bit tp, bit pcs, bit s1, bit s2,
                                     logic [1:0] s3, bit s4, logic [2:0] alu, bit done);
    return {ldpc, ldir, lda, mr, mw, pu, po, tp, pcs, s1, s2, s3, s4, alu, done};
  endfunction

  logic [17:0] E_ZERO, E_FETCH, E_PMEM, E_PWR, E_PRD, E_PWB, E_OPA, E_OPB, E_WB;
  logic [17:0] E_JTOP, E_JZ1, E_JZ0, E_JMP;

  initial begin
    E_ZERO  = '0;
    E_FETCH = cv(1,1,0,1,0, 0,0,0, 0,0,1, 2'b01, 0, 3'b000, 0);
    E_PMEM  = cv(0,0,0,1,0, 0,0,0, 0,1,0, 2'b00, 0, 3'b000, 0);
    E_PWR   = cv(0,0,0,0,0, 1,0,0, 0,0,0, 2'b00, 0, 3'b000, 1);
    E_PRD   = cv(0,0,1,0,0, 0,1,0, 0,0,0, 2'b00, 0, 3'b000, 0);
    E_PWB   = cv(0,0,0,0,1, 0,0,0, 0,1,0, 2'b00, 0, 3'b000, 1);
    E_OPA   = cv(0,0,1,0,0, 0,1,0, 0,0,0, 2'b00, 0, 3'b000, 0);
    E_OPB   = cv(0,0,0,0,0, 0,1,0, 0,0,0, 2'b00, 0, 3'b000, 0);
    E_WB    = cv(0,0,0,0,0, 1,0,0, 0,0,0, 2'b00, 1, 3'b000, 1);
    E_JTOP  = cv(0,0,1,0,0, 0,0,1, 0,0,0, 2'b00, 0, 3'b000, 0);
    E_JZ1   = cv(1,0,0,0,0, 0,0,0, 1,0,0, 2'b00, 0, 3'b100, 1);
    E_JZ0   = cv(0,0,0,0,0, 0,0,0, 0,0,0, 2'b00, 0, 3'b100, 1);
    E_JMP   = cv(1,0,0,0,0, 0,0,0, 1,0,0, 2'b00, 0, 3'b000, 1);
  end

  function automatic logic [17:0] ex_op(logic [2:0] alu);
    return cv(0,0,0,0,0, 0,0,0, 0,0,0, 2'b00, 0, alu, 0);
  endfunction

  // One clock of stimulus: set inputs just after the edge, queue what this cycle must show.
  task automatic step(input logic r, input logic [8:0] i, input logic z,
                      input logic [17:0] e, input string n);
    exp_t x;
    @(posedge clk);
    #1;
    rst      = r;
    bus.inst = i;
    bus.Zero = z;
    x.v    = e;
    x.name = n;
    q.push_back(x);
  endtask

  task automatic run_alu(input logic [8:0] i, input string n, input logic [2:0] alu,
                         input bit is_not);
    step(0, i, 0, E_FETCH, {n, "_fetch"});
    step(0, i, 0, E_ZERO,  {n, "_decode"});
    step(0, i, 0, E_OPA,   {n, "_op_a"});
    if (!is_not) step(0, i, 0, E_OPB, {n, "_op_b"});
    step(0, i, 0, ex_op(alu), {n, "_op_ex"});
    step(0, i, 0, E_WB,    {n, "_op_wb"});
  endtask

  // Monitor: compare the whole control word whenever an expectation is pending.
  initial begin
    exp_t        x;
    logic [17:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x   = q.pop_front();
        act = {bus.ld_PC, bus.ld_IR, bus.ld_A, bus.MemRead, bus.MemWrite,
               bus.push, bus.pop, bus.top, bus.PCsrc, bus.s1, bus.s2,
               bus.s3, bus.s4, bus.ALU_operation, bus.instr_done};
        n_cmp++;
        if (act !== x.v) begin
          n_bad++;
          $display("FAIL %s: got %b expected %b", x.name, act, x.v);
        end
      end
    end
  end

  initial begin
    bus.inst = '0;
    bus.Zero = 1'b0;
    rst      = 1'b1;

    step(1, 9'b0_000_00000, 0, E_ZERO, "reset_0");
    step(1, 9'b0_000_00000, 0, E_ZERO, "reset_1");

    // PUSH 3
    step(0, 9'b0_100_00011, 0, E_FETCH, "push_fetch");
    step(0, 9'b0_100_00011, 0, E_ZERO,  "push_decode");
    step(0, 9'b0_100_00011, 0, E_PMEM,  "push_mem");
    step(0, 9'b0_100_00011, 0, E_PWR,   "push_wr");

    run_alu(9'b0_000_10101, "add", 3'b000, 0);
    run_alu(9'b1_001_00000, "sub", 3'b001, 0);
    run_alu(9'b0_010_11111, "and", 3'b010, 0);
    run_alu(9'b0_011_00100, "not", 3'b011, 1);

    // POP 7
    step(0, 9'b0_101_00111, 0, E_FETCH, "pop_fetch");
    step(0, 9'b0_101_00111, 0, E_ZERO,  "pop_decode");
    step(0, 9'b0_101_00111, 0, E_PRD,   "pop_rd");
    step(0, 9'b0_101_00111, 0, E_PWB,   "pop_wr");

    // JZ 10 taken, then not taken
    step(0, 9'b0_111_01010, 0, E_FETCH, "jz1_fetch");
    step(0, 9'b0_111_01010, 0, E_ZERO,  "jz1_decode");
    step(0, 9'b0_111_01010, 0, E_JTOP,  "jz1_top");
    step(0, 9'b0_111_01010, 1, E_JZ1,   "jz1_ex");
    step(0, 9'b0_111_01010, 1, E_FETCH, "jz0_fetch");
    step(0, 9'b0_111_01010, 1, E_ZERO,  "jz0_decode");
    step(0, 9'b0_111_01010, 1, E_JTOP,  "jz0_top");
    step(0, 9'b0_111_01010, 0, E_JZ0,   "jz0_ex");

    // JMP 31, followed immediately by FETCH
    step(0, 9'b0_110_11111, 0, E_FETCH, "jmp_fetch");
    step(0, 9'b0_110_11111, 0, E_JMP,   "jmp_decode");
    step(0, 9'b0_110_11111, 0, E_FETCH, "jmp_next_fetch");
    step(0, 9'b0_110_11111, 0, E_JMP,   "jmp2_decode");

    // reset held 3 cycles in the middle of an ADD
    step(0, 9'b0_000_00001, 0, E_FETCH, "rstmid_fetch");
    step(0, 9'b0_000_00001, 0, E_ZERO,  "rstmid_decode");
    step(0, 9'b0_000_00001, 0, E_OPA,   "rstmid_op_a");
    step(1, 9'b0_000_00001, 0, E_ZERO,  "rstmid_rst0");
    step(1, 9'b0_000_00001, 0, E_ZERO,  "rstmid_rst1");
    step(1, 9'b0_000_00001, 0, E_ZERO,  "rstmid_rst2");
    step(0, 9'b0_000_00001, 0, E_FETCH, "rstmid_fetch_after");
    step(0, 9'b0_000_00001, 0, E_ZERO,  "rstmid_decode_after");
    step(0, 9'b0_000_00001, 0, E_OPA,   "rstmid_op_a_after");

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, need 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
